// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue with credit-limited memory requests
// Optional macro FETCH_BYPASS_EN: an empty queue lets a response load id_* directly.
module fetch_queue #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        ce,
  input  logic        branch_valid,
  input  logic [5:0]  stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        stallreq_if
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
  localparam logic [31:0]   NOP = 32'h00000013;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] inflight;
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;
  logic [31:0]   tag_mem [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_inst  [QDEPTH];
  logic          rsp_accept;
  logic          rsp_keep;
  logic          bypass;
  logic          q_push;
  logic          q_pop;
  logic          stall_unused;

  assign stall_unused = ^stall[5:2];

  assign inflight    = outstanding + occupancy;
  assign imem_req    = ~rst & ce & ~stall[0] & ~branch_valid & (inflight < DEPTH_C);
  assign imem_addr   = pc_addr;
  assign stallreq_if = ~rst & (inflight == DEPTH_C);

  // A response with nothing outstanding belongs to a request issued before reset.
  assign rsp_accept = imem_rvalid & (outstanding != '0);
  assign rsp_keep   = rsp_accept & (drop_cnt == '0) & ~branch_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep & (occupancy == '0) & ~stall[1];
`else
  assign bypass = 1'b0;
`endif

  assign q_push = rsp_keep & ~bypass;
  assign q_pop  = ~branch_valid & ~stall[1] & (occupancy != '0);

  always_ff @(posedge clk) begin
    if (imem_req) tag_mem[tag_wr] <= pc_addr;
    if (q_push) begin
      q_pc[q_wr]   <= tag_mem[tag_rd];
      q_inst[q_wr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      occupancy   <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      id_pc       <= '0;
      id_inst     <= NOP;
      id_valid    <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(imem_req) - CW'(rsp_accept);
      if (imem_req)   tag_wr <= tag_wr + PW'(1);
      if (rsp_accept) tag_rd <= tag_rd + PW'(1);

      if (branch_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        drop_cnt  <= outstanding - CW'(rsp_accept);
        occupancy <= '0;
        q_wr      <= '0;
        q_rd      <= '0;
        id_valid  <= 1'b0;
        id_inst   <= NOP;
      end else begin
        if (rsp_accept && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        occupancy <= occupancy + CW'(q_push) - CW'(q_pop);
        if (q_push) q_wr <= q_wr + PW'(1);
        if (q_pop)  q_rd <= q_rd + PW'(1);
        if (!stall[1]) begin
          if (q_pop) begin
            id_pc    <= q_pc[q_rd];
            id_inst  <= q_inst[q_rd];
            id_valid <= 1'b1;
          end else if (bypass) begin
            id_pc    <= tag_mem[tag_rd];
            id_inst  <= imem_rdata;
            id_valid <= 1'b1;
          end else begin
            id_valid <= 1'b0;
            id_inst  <= NOP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;
  localparam int QDEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_BYPASS_EN
  localparam int MIN_LAT = 0;
`else
  localparam int MIN_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        ce;
  logic        branch_valid;
  logic [5:0]  stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        stallreq_if;

  fetch_queue #(.QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .ce(ce), .branch_valid(branch_valid),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int gen; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; int edge_no; } exp_t;

  mreq_t mem_q[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    gen = 0;
  int    epoch = 0;
  int    last_due = 0;
  int    lat_mode = 1;
  logic [31:0] pc = 32'h0;

  logic want_rst = 1'b1, want_ce = 1'b0, want_br = 1'b0, br_on_rv = 1'b0, br_taken = 1'b0;
  logic [5:0] want_stall = 6'b0;

  // Inputs as sampled at the coming edge, shared by the model and the monitor.
  logic s_rst = 1'b1, s_br = 1'b0, s_st1 = 1'b0, s_rv = 1'b0, s_req = 1'b0;
  logic [31:0] s_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    int  outm;
    bit  old_pending;
    bit  rv;
    logic exp_req;
    @(negedge clk);
    outm = 0;
    old_pending = 0;
    foreach (mem_q[i]) begin
      if (mem_q[i].gen != gen) old_pending = 1;
      else outm++;
    end
    rv = (mem_q.size() > 0) && (mem_q[0].due == cyc + 1);
    imem_rvalid  = rv;
    imem_rdata   = rv ? mem_word(mem_q[0].addr) : $urandom();
    rst          = want_rst;
    ce           = want_ce & ~old_pending;
    stall        = want_stall;
    branch_valid = br_on_rv ? rv : want_br;
    pc_addr      = pc;
    #1;
    if (rst) begin
      check("req_in_rst", {31'b0, imem_req}, 32'd0);
      check("stallreq_in_rst", {31'b0, stallreq_if}, 32'd0);
    end else begin
      exp_req = ce & ~stall[0] & ~branch_valid & ((outm + sb.size()) < QDEPTH);
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      check("stallreq_if", {31'b0, stallreq_if}, {31'b0, ((outm + sb.size()) == QDEPTH)});
      if (exp_req) check("imem_addr", imem_addr, pc);
    end
    s_rst  = rst;
    s_br   = branch_valid;
    s_st1  = stall[1];
    s_rv   = rv;
    s_req  = imem_req;
    s_addr = imem_addr;
    if (branch_valid) br_taken = 1'b1;
    if (rst) pc = 32'h0;
    else if (branch_valid) pc = $urandom() & 32'h00000FFC;
    else if (imem_req) pc = pc + 32'd4;
  endtask

  // Reference model: a response reaches decode only if no flush or reset
  // intervened since its request; a flush discards all not-yet-presented work.
  always @(posedge clk) begin : model_blk
    mreq_t m;
    exp_t  e;
    int    lat;
    int    due;
    #1;
    cyc++;
    if (s_rv) begin
      m = mem_q.pop_front();
      if (!s_rst && m.epoch == epoch) begin
        e.pc = m.addr;
        e.inst = mem_word(m.addr);
        e.edge_no = cyc;
        sb.push_back(e);
      end
    end
    if (s_req) begin
      lat = (lat_mode == 0) ? int'($urandom_range(1, 8)) : lat_mode;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = s_addr;
      m.due = due;
      m.gen = gen;
      m.epoch = epoch;
      mem_q.push_back(m);
    end
    if (s_rst) begin
      gen++;
      epoch++;
      sb.delete();
    end else if (s_br) begin
      epoch++;
      sb.delete();
    end
  end

  always @(posedge clk) begin : monitor_blk
    exp_t e;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic        prev_valid;
    bit          stale;
    #2;
    if (s_rst) begin
      check("rst_id_pc", id_pc, 32'h0);
      check("rst_id_inst", id_inst, NOP);
      check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    end else if (s_br) begin
      check("flush_id_valid", {31'b0, id_valid}, 32'd0);
      check("flush_id_inst", id_inst, NOP);
    end else if (s_st1) begin
      check("hold_id_pc", id_pc, prev_pc);
      check("hold_id_inst", id_inst, prev_inst);
      check("hold_id_valid", {31'b0, id_valid}, {31'b0, prev_valid});
    end else if (id_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected nothing (edge %0d)", id_pc, id_inst, cyc);
      end else begin
        e = sb.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_inst", id_inst, e.inst);
        check("latency_ok", {31'b0, (cyc - e.edge_no) >= MIN_LAT}, 32'd1);
      end
    end else begin
      check("idle_id_inst", id_inst, NOP);
      stale = (sb.size() > 0) && ((cyc - sb[0].edge_no) >= MIN_LAT);
      check("no_starve", {31'b0, stale}, 32'd0);
    end
    prev_pc = id_pc;
    prev_inst = id_inst;
    prev_valid = id_valid;
  end

  initial begin
    rst = 1'b1; ce = 1'b0; branch_valid = 1'b0; stall = 6'b0;
    pc_addr = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    repeat (3) step();
    want_rst = 1'b0;

    // 1-cycle memory, first fetch from pc 0
    lat_mode = 1; want_ce = 1'b1;
    repeat (12) step();

    // slow memory exhausts credits
    lat_mode = 8;
    repeat (30) step();

    // decode held while responses arrive, then released
    lat_mode = 2; want_stall = 6'b000010;
    repeat (10) step();
    want_stall = 6'b0;
    repeat (10) step();

    // redirect with requests in flight and instructions queued
    lat_mode = 5; want_stall = 6'b000010;
    repeat (5) step();
    want_br = 1'b1;
    step();
    want_br = 1'b0; want_stall = 6'b0;
    repeat (20) step();

    // redirect coincident with decode hold and a returning response
    lat_mode = 3;
    repeat (6) step();
    want_stall = 6'b000010; br_on_rv = 1'b1; br_taken = 1'b0;
    for (int i = 0; i < 20 && !br_taken; i++) step();
    check("flush_with_rv_seen", {31'b0, br_taken}, 32'd1);
    br_on_rv = 1'b0; want_stall = 6'b0;
    repeat (15) step();

    // reset with requests outstanding
    lat_mode = 6;
    repeat (3) step();
    want_rst = 1'b1;
    step();
    want_rst = 1'b0;
    repeat (25) step();

    // randomized traffic
    lat_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      want_ce    = ($urandom_range(0, 99) < 85);
      want_stall = {4'b0, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15)};
      want_br    = ($urandom_range(0, 99) < 4);
      want_rst   = ($urandom_range(0, 999) < 5);
      step();
    end

    // drain
    want_ce = 1'b0; want_stall = 6'b0; want_br = 1'b0; want_rst = 1'b0;
    repeat (20) step();
    check("drain_sb_empty", sb.size(), 32'd0);
    check("drain_mem_empty", mem_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
